// File: rtl/motor_move_sched_pkg.sv
// Shared types and helpers for the stepper move scheduler.
// Holds the FSM state encoding, requester indices and the fixed-priority pick.
package motor_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int REQ_QR  = 0;
    localparam int REQ_GEO = 1;
    localparam int REQ_GPS = 2;

    localparam int MIN_PERIOD_DEF = 2;

    // Lowest index wins: QR over geo over gps.
    function automatic logic [1:0] pick_req(input logic [2:0] valid);
        if (valid[REQ_QR])       return 2'(REQ_QR);
        else if (valid[REQ_GEO]) return 2'(REQ_GEO);
        else                     return 2'(REQ_GPS);
    endfunction

    function automatic logic [2:0] lowest_one(input logic [2:0] valid);
        return valid & (~valid + 3'd1);
    endfunction

endpackage

// File: rtl/motor_move_sched_if.sv
// Request bus between the three move requesters and the scheduler.
// Slice i of req_steps/req_period belongs to requester i (0 QR, 1 geo, 2 gps).
interface motor_move_sched_if #(
    parameter int STEP_W = 16,
    parameter int PER_W  = 16
);
    logic [2:0]          req_valid;
    logic [2:0]          req_ready;
    logic [2:0]          req_dir;
    logic [3*STEP_W-1:0] req_steps;
    logic [3*PER_W-1:0]  req_period;

    modport master (
        output req_valid, req_dir, req_steps, req_period,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_dir, req_steps, req_period,
        output req_ready
    );
endinterface

// File: rtl/motor_move_sched_rate.sv
// Step-period down-counter: tick when the count is 0 while running, then reload period-1.
// load takes priority and primes the counter so the first tick lands period cycles later.
module step_rate_gen #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [PER_W-1:0] period,
    output logic             tick
);
    logic [PER_W-1:0] cnt;

    // NOTE: clocked state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= period - PER_W'(1);
        end else if (run) begin
            cnt <= (cnt == '0) ? period - PER_W'(1) : cnt - PER_W'(1);
        end
    end

    assign tick = run && (cnt == '0);

endmodule

// File: rtl/motor_move_sched.sv
// Move scheduler: grants one requester at a time and emits an exact number of step
// pulses at the latched period, after a fixed direction-settle gap.
module motor_move_sched
    import motor_sched_pkg::*;
#(
    parameter int STEP_W     = 16,
    parameter int PER_W      = 16,
    parameter int DIR_SETTLE = 8,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    motor_move_sched_if.slave req,
    input  logic              abort,
    output logic              step_pulse,
    output logic              step_dir,
    output logic              step_en,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic [STEP_W-1:0] steps_left,
    output logic              done,
    output logic              aborted
);
    localparam int SET_W = $clog2(DIR_SETTLE + 1);

    state_t             state, state_nxt;
    logic               dir_q;
    logic               abort_q;
    logic               end_by_abort;
    logic [PER_W-1:0]   period_q;
    logic [SET_W-1:0]   settle_cnt;

    logic               grant;
    logic [1:0]         sel;
    logic               sel_dir;
    logic [STEP_W-1:0]  sel_steps;
    logic [PER_W-1:0]   sel_period_raw;
    logic [PER_W-1:0]   sel_period;

    logic               tick;
    logic               rate_load;
    logic               rate_run;
    logic               last_step;

    // Request decode is only consumed on the grant cycle.
    always_comb begin
        sel            = pick_req(req.req_valid);
        grant          = (state == ST_IDLE) && (|req.req_valid);
        sel_dir        = req.req_dir[sel];
        sel_steps      = req.req_steps[int'(sel)*STEP_W +: STEP_W];
        sel_period_raw = req.req_period[int'(sel)*PER_W +: PER_W];
        sel_period     = (sel_period_raw < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD)
                                                                : sel_period_raw;
    end

    assign rate_run  = (state == ST_RUN);
    assign rate_load = (state == ST_SETTLE) && !abort
                       && (settle_cnt == SET_W'(DIR_SETTLE - 1));
    assign last_step = tick && (steps_left == STEP_W'(1));

    step_rate_gen #(.PER_W(PER_W)) u_rate (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (rate_load),
        .run    (rate_run),
        .period (period_q),
        .tick   (tick)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        end_by_abort  = 1'b0;
        req.req_ready = '0;
        step_en       = 1'b0;
        step_dir      = dir_q;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    req.req_ready = lowest_one(req.req_valid);
                    step_en       = 1'b1;
                    step_dir      = sel_dir;
                    state_nxt     = (sel_steps == '0) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                step_en = 1'b1;
                if (abort) begin
                    state_nxt    = ST_DONE;
                    end_by_abort = 1'b1;
                end else if (rate_load) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                step_en = 1'b1;
                // A final pulse completes the move even if abort arrives with it.
                if (last_step) begin
                    state_nxt = ST_DONE;
                end else if (abort) begin
                    state_nxt    = ST_DONE;
                    end_by_abort = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign step_pulse = tick;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign aborted    = done && abort_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dir_q      <= 1'b0;
            abort_q    <= 1'b0;
            period_q   <= '0;
            settle_cnt <= '0;
            steps_left <= '0;
            grant_id   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                dir_q      <= sel_dir;
                period_q   <= sel_period;
                steps_left <= sel_steps;
                grant_id   <= sel;
                abort_q    <= 1'b0;
                settle_cnt <= '0;
            end
            if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end
            if (tick) begin
                steps_left <= steps_left - STEP_W'(1);
            end
            if (end_by_abort) begin
                abort_q <= 1'b1;
            end
        end
    end

endmodule
